// File: rtl/interrupt_sequencer_if.sv
// Memory bus between the interrupt sequencer (master) and the memory/arbiter (slave).
interface interrupt_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [7:0]            bus_wdata;
    logic                  bus_we;
    logic                  bus_re;
    logic [7:0]            bus_rdata;
    logic                  bus_ready;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: pushes PC (and flags when INTERRUPT_SEQUENCER_FLAGS_SAVE_EN
// is defined), fetches the handler vector, loads PC, then waits for reti.
module interrupt_sequencer #(
    parameter int unsigned           WIDTH       = 4,
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE = ADDR_WIDTH'(8'hF0)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      interrupt_in,
    output logic                  processing,
    input  logic                  instr_boundary,
    input  logic                  ei,
    input  logic                  di,
    input  logic                  reti,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [ADDR_WIDTH-1:0] sp_in,
    input  logic [7:0]            flags_in,
    output logic                  cpu_hold,
    output logic                  sp_dec,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_load_value,
    interrupt_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_PC,
`ifdef INTERRUPT_SEQUENCER_FLAGS_SAVE_EN
        PUSH_FL,
`endif
        VECTOR,
        JUMP,
        ACTIVE,
        RELEASE
    } state_t;

    state_t                state;
    logic                  ie;
    logic [WIDTH-1:0]      code_q;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] vector_addr;

    assign accept      = (state == IDLE) && (interrupt_in != '0) && ie && instr_boundary;
    assign vector_addr = VECTOR_BASE + ADDR_WIDTH'(code_q);

`ifdef INTERRUPT_SEQUENCER_FLAGS_SAVE_EN
    logic [7:0] flags_q;
    logic       unused_pc;
    assign unused_pc = ^pc_in;
`else
    // Flags are not saved in this build; upper PC bits never reach the 8-bit bus.
    logic unused_inputs;
    assign unused_inputs = ^{flags_in, pc_in};
`endif

    // Sequencer state, interrupt enable and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            ie             <= 1'b0;
            code_q         <= '0;
            processing     <= 1'b0;
            cpu_hold       <= 1'b0;
            sp_dec         <= 1'b0;
            pc_load        <= 1'b0;
            pc_load_value  <= '0;
            bus.bus_addr   <= '0;
            bus.bus_wdata  <= '0;
            bus.bus_we     <= 1'b0;
            bus.bus_re     <= 1'b0;
`ifdef INTERRUPT_SEQUENCER_FLAGS_SAVE_EN
            flags_q        <= '0;
`endif
        end else begin
            // di dominates ei and the reti re-enable; accept dominates everything
            if (accept)                          ie <= 1'b0;
            else if (di)                         ie <= 1'b0;
            else if ((state == ACTIVE) && reti)  ie <= 1'b1;
            else if (ei)                         ie <= 1'b1;

            sp_dec  <= 1'b0;
            pc_load <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= PUSH_PC;
                        code_q        <= interrupt_in;
                        processing    <= 1'b1;
                        cpu_hold      <= 1'b1;
                        bus.bus_we    <= 1'b1;
                        bus.bus_addr  <= sp_in - ADDR_WIDTH'(1);
                        bus.bus_wdata <= pc_in[7:0];
`ifdef INTERRUPT_SEQUENCER_FLAGS_SAVE_EN
                        flags_q       <= flags_in;
`endif
                    end
                end
                PUSH_PC: begin
                    if (bus.bus_ready) begin
                        sp_dec <= 1'b1;
`ifdef INTERRUPT_SEQUENCER_FLAGS_SAVE_EN
                        // sp_in has not yet seen this decrement, hence -2
                        state         <= PUSH_FL;
                        bus.bus_addr  <= sp_in - ADDR_WIDTH'(2);
                        bus.bus_wdata <= flags_q;
`else
                        state         <= VECTOR;
                        bus.bus_we    <= 1'b0;
                        bus.bus_re    <= 1'b1;
                        bus.bus_addr  <= vector_addr;
                        bus.bus_wdata <= '0;
`endif
                    end
                end
`ifdef INTERRUPT_SEQUENCER_FLAGS_SAVE_EN
                PUSH_FL: begin
                    if (bus.bus_ready) begin
                        sp_dec        <= 1'b1;
                        state         <= VECTOR;
                        bus.bus_we    <= 1'b0;
                        bus.bus_re    <= 1'b1;
                        bus.bus_addr  <= vector_addr;
                        bus.bus_wdata <= '0;
                    end
                end
`endif
                VECTOR: begin
                    if (bus.bus_ready) begin
                        state         <= JUMP;
                        bus.bus_re    <= 1'b0;
                        bus.bus_addr  <= '0;
                        pc_load       <= 1'b1;
                        pc_load_value <= ADDR_WIDTH'(bus.bus_rdata);
                    end
                end
                JUMP: begin
                    state    <= ACTIVE;
                    cpu_hold <= 1'b0;
                end
                ACTIVE: begin
                    if (reti) begin
                        state      <= RELEASE;
                        processing <= 1'b0;
                    end
                end
                RELEASE: state <= IDLE;
                default: begin
                    state      <= IDLE;
                    processing <= 1'b0;
                    cpu_hold   <= 1'b0;
                    bus.bus_we <= 1'b0;
                    bus.bus_re <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer; a second instance uses VECTOR_BASE=8'hFE.
module tb_interrupt_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] interrupt_in;
    logic       instr_boundary, ei, di, reti;
    logic [7:0] pc_in, sp_in, flags_in;
    logic       bus_ready;
    logic [7:0] bus_rdata;

    logic       processing, cpu_hold, sp_dec, pc_load;
    logic [7:0] pc_load_value;
    logic       processing2, cpu_hold2, sp_dec2, pc_load2;
    logic [7:0] pc_load_value2;

    int checks = 0;
    int errors = 0;

    interrupt_sequencer_if #(.ADDR_WIDTH(8)) bus1 ();
    interrupt_sequencer_if #(.ADDR_WIDTH(8)) bus2 ();

    assign bus1.bus_ready = bus_ready;
    assign bus1.bus_rdata = bus_rdata;
    assign bus2.bus_ready = bus_ready;
    assign bus2.bus_rdata = bus_rdata;

    interrupt_sequencer #(.WIDTH(4), .ADDR_WIDTH(8), .VECTOR_BASE(8'hF0)) dut (
        .clk(clk), .rst_n(rst_n), .interrupt_in(interrupt_in), .processing(processing),
        .instr_boundary(instr_boundary), .ei(ei), .di(di), .reti(reti),
        .pc_in(pc_in), .sp_in(sp_in), .flags_in(flags_in),
        .cpu_hold(cpu_hold), .sp_dec(sp_dec), .pc_load(pc_load),
        .pc_load_value(pc_load_value), .bus(bus1)
    );

    interrupt_sequencer #(.WIDTH(4), .ADDR_WIDTH(8), .VECTOR_BASE(8'hFE)) dut2 (
        .clk(clk), .rst_n(rst_n), .interrupt_in(interrupt_in), .processing(processing2),
        .instr_boundary(instr_boundary), .ei(ei), .di(di), .reti(reti),
        .pc_in(pc_in), .sp_in(sp_in), .flags_in(flags_in),
        .cpu_hold(cpu_hold2), .sp_dec(sp_dec2), .pc_load(pc_load2),
        .pc_load_value(pc_load_value2), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; interrupt_in = 4'h0; instr_boundary = 1'b0;
        ei = 1'b0; di = 1'b0; reti = 1'b0;
        pc_in = 8'h00; sp_in = 8'h80; flags_in = 8'hA5;
        bus_ready = 1'b1; bus_rdata = 8'h00;
        step(); step();
        chk("rst_processing", 32'(processing), 32'h0);
        chk("rst_cpu_hold",   32'(cpu_hold), 32'h0);
        chk("rst_we",         32'(bus1.bus_we), 32'h0);
        chk("rst_re",         32'(bus1.bus_re), 32'h0);
        chk("rst_sp_dec",     32'(sp_dec), 32'h0);
        chk("rst_pc_load",    32'(pc_load), 32'h0);
        chk("rst_addr",       32'(bus1.bus_addr), 32'h0);
        chk("rst_wdata",      32'(bus1.bus_wdata), 32'h0);
        chk("rst_pcv",        32'(pc_load_value), 32'h0);

        // Pending code 1 with ie=0: no accept
        rst_n = 1'b1; interrupt_in = 4'h1; instr_boundary = 1'b1;
        pc_in = 8'h11; bus_rdata = 8'h5A;
        step(); chk("ie0_no_accept_a", 32'(processing), 32'h0);
        step(); chk("ie0_no_accept_b", 32'(processing), 32'h0);
        reti = 1'b1; step(); reti = 1'b0; step();
        chk("reti_idle_ignored", 32'(processing), 32'h0);
        ei = 1'b1; di = 1'b1; step(); ei = 1'b0; di = 1'b0; step();
        chk("ei_di_together", 32'(processing), 32'h0);
        ei = 1'b1; instr_boundary = 1'b0; step(); ei = 1'b0; step();
        chk("no_boundary", 32'(processing), 32'h0);

        // Entry 1: code 1, bus stalls in VECTOR
        instr_boundary = 1'b1; step();
        chk("e1_processing", 32'(processing), 32'h1);
        chk("e1_cpu_hold",   32'(cpu_hold), 32'h1);
        chk("e1_we",         32'(bus1.bus_we), 32'h1);
        chk("e1_re",         32'(bus1.bus_re), 32'h0);
        chk("e1_push_addr",  32'(bus1.bus_addr), 32'h7F);
        chk("e1_push_data",  32'(bus1.bus_wdata), 32'h11);
        chk("e1_sp_dec_lo",  32'(sp_dec), 32'h0);
        interrupt_in = 4'h7;
        step();
`ifdef INTERRUPT_SEQUENCER_FLAGS_SAVE_EN
        chk("e1_fl_we",      32'(bus1.bus_we), 32'h1);
        chk("e1_fl_addr",    32'(bus1.bus_addr), 32'h7E);
        chk("e1_fl_data",    32'(bus1.bus_wdata), 32'hA5);
        chk("e1_fl_sp_dec",  32'(sp_dec), 32'h1);
        sp_in = 8'h7F;
        step();
`endif
        chk("e1_vec_re",     32'(bus1.bus_re), 32'h1);
        chk("e1_vec_we",     32'(bus1.bus_we), 32'h0);
        chk("e1_vec_addr",   32'(bus1.bus_addr), 32'hF1);
        chk("e1_vec_addr2",  32'(bus2.bus_addr), 32'hFF);
        chk("e1_sp_dec",     32'(sp_dec), 32'h1);
        bus_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_re",      32'(bus1.bus_re), 32'h1);
            chk("stall_addr",    32'(bus1.bus_addr), 32'hF1);
            chk("stall_pc_load", 32'(pc_load), 32'h0);
            chk("stall_sp_dec",  32'(sp_dec), 32'h0);
        end
        bus_ready = 1'b1; step();
        chk("e1_pc_load",    32'(pc_load), 32'h1);
        chk("e1_pcv",        32'(pc_load_value), 32'h5A);
        chk("e1_jump_re",    32'(bus1.bus_re), 32'h0);
        chk("e1_jump_hold",  32'(cpu_hold), 32'h1);
        step();
        chk("e1_act_pc_load", 32'(pc_load), 32'h0);
        chk("e1_act_hold",    32'(cpu_hold), 32'h0);
        chk("e1_act_proc",    32'(processing), 32'h1);
        step();
        chk("e1_wait_reti",   32'(processing), 32'h1);
        reti = 1'b1; di = 1'b1; step(); reti = 1'b0; di = 1'b0;
        chk("e1_release",     32'(processing), 32'h0);
        step(); chk("e1_idle",  32'(processing), 32'h0);
        step(); chk("di_with_reti_ie0", 32'(processing), 32'h0);

        // Entry 2: code 3, full speed, ei held through the accept
        interrupt_in = 4'h3; pc_in = 8'h42; sp_in = 8'h80; bus_rdata = 8'hC8;
        ei = 1'b1; step(); step(); ei = 1'b0;
        chk("e2_processing", 32'(processing), 32'h1);
        chk("e2_push_addr",  32'(bus1.bus_addr), 32'h7F);
        chk("e2_push_data",  32'(bus1.bus_wdata), 32'h42);
        step();
`ifdef INTERRUPT_SEQUENCER_FLAGS_SAVE_EN
        chk("e2_fl_addr",    32'(bus1.bus_addr), 32'h7E);
        chk("e2_fl_data",    32'(bus1.bus_wdata), 32'hA5);
        sp_in = 8'h7F;
        step();
`endif
        chk("e2_vec_re",     32'(bus1.bus_re), 32'h1);
        chk("e2_vec_addr",   32'(bus1.bus_addr), 32'hF3);
        chk("e2_vec_addr2",  32'(bus2.bus_addr), 32'h01);
        chk("e2_sp_dec",     32'(sp_dec), 32'h1);
        step();
        chk("e2_pc_load",    32'(pc_load), 32'h1);
        chk("e2_pcv",        32'(pc_load_value), 32'hC8);
        step();
        chk("e2_active",     32'(processing), 32'h1);
        chk("e2_act_pc_load", 32'(pc_load), 32'h0);
        reti = 1'b1; interrupt_in = 4'h5; step(); reti = 1'b0;
        chk("e2_release",    32'(processing), 32'h0);
        chk("e2_rel_we",     32'(bus1.bus_we), 32'h0);
        chk("e2_rel_re",     32'(bus1.bus_re), 32'h0);
        step();
        chk("release_ignores_head", 32'(processing), 32'h0);

        // Entry 3: code 5, reset while in VECTOR
        sp_in = 8'h80;
        step();
        chk("e3_processing", 32'(processing), 32'h1);
        chk("e3_push_addr",  32'(bus1.bus_addr), 32'h7F);
        step();
`ifdef INTERRUPT_SEQUENCER_FLAGS_SAVE_EN
        sp_in = 8'h7F;
        step();
`endif
        chk("e3_vec_addr",   32'(bus1.bus_addr), 32'hF5);
        chk("e3_vec_addr2",  32'(bus2.bus_addr), 32'h03);
        chk("e3_proc2",      32'(processing2), 32'h1);
        rst_n = 1'b0; step();
        chk("mid_rst_processing", 32'(processing), 32'h0);
        chk("mid_rst_hold",  32'(cpu_hold), 32'h0);
        chk("mid_rst_re",    32'(bus1.bus_re), 32'h0);
        chk("mid_rst_we",    32'(bus1.bus_we), 32'h0);
        chk("mid_rst_addr",  32'(bus1.bus_addr), 32'h0);
        chk("mid_rst_pcl",   32'(pc_load), 32'h0);
        chk("mid_rst_pcv",   32'(pc_load_value), 32'h0);
        chk("mid_rst_spd",   32'(sp_dec), 32'h0);
        rst_n = 1'b1; step();
        chk("post_rst_idle", 32'(processing), 32'h0);
        chk("post_rst_re",   32'(bus1.bus_re), 32'h0);
        chk("post_rst_pcl",  32'(pc_load), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
